product_accumulator: RTL

Sequential consumer stage placed directly downstream of the 4x4 array multiplier. It accepts a stream of unsigned 8-bit products through a valid/ready handshake and sums a programmed number of them into a registered accumulator. It then presents the total with a completion flag. Typical use is a dot-product or multiply-accumulate over up to 15 operand pairs, with the multiplier output wired straight to the product input.

---
 rtl/product_accumulator_if.sv | 32 +++
 rtl/product_accumulator.sv | 91 +++++++++
 2 files changed

// File: rtl/product_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator_if
// Description : Valid/ready product stream and result bus of the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface product_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 4
);
    logic              start;
    logic [CNT_W-1:0]  num_terms;
    logic              prod_valid;
    logic [PROD_W-1:0] product;
    logic              prod_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output start, num_terms, prod_valid, product,
        input  prod_ready, acc_out, busy, done, overflow
    );

    modport slave (
        input  start, num_terms, prod_valid, product,
        output prod_ready, acc_out, busy, done, overflow
    );
endinterface
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Sums a programmed number of unsigned products with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    product_accumulator_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]   rem_q,   rem_d;
    logic               ovf_q,   ovf_d;
    logic [ACC_W:0]     sum;

    // One extra bit catches the carry that signals saturation.
    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.product};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (bus.num_terms != '0) begin
                        state_d = S_ACCUM;
                        rem_d   = bus.num_terms;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCUM: begin
                if (bus.prod_valid) begin
                    if (sum[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    rem_d = rem_q - {{(CNT_W - 1){1'b0}}, 1'b1};
                    if (rem_q == {{(CNT_W - 1){1'b0}}, 1'b1}) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.prod_ready = (state_q == S_ACCUM);
    assign bus.busy       = (state_q == S_ACCUM);
    assign bus.done       = (state_q == S_DONE);
    assign bus.acc_out    = acc_q;
    assign bus.overflow   = ovf_q;

endmodule
`default_nettype wire
